pb_debounce_array: RTL

Multi-channel, parametrised successor to the single-input millisecond debouncer on the ICE board. It conditions NCH asynchronous pushbutton or switch inputs with per-bit polarity, and produces debounced levels plus one-cycle press and release pulses. All channels share one millisecond prescaler. It sits between the board pins (PB, DIP) and ice_bus/reset logic in the ICE top level, on the buffered system clock.

---
 rtl/pb_debounce_pkg.sv | 28 ++
 rtl/pb_debounce_chan.sv | 101 ++++++++++
 rtl/pb_debounce_array.sv | 66 ++++++
 3 files changed

// File: rtl/pb_debounce_pkg.sv
// Shared constants, width helpers and the channel level type for the pushbutton debouncer.
// Optional long-press detection is built only when PB_DEBOUNCE_LONGPRESS_EN is defined.
package pb_debounce_pkg;

  localparam int DEF_PRESCALE = 20000;
  localparam int DEF_DB_MS    = 10;
  localparam int DEF_LONG_MS  = 1000;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits for a count range of 1.
  function automatic int bits_for(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One debounced channel: polarity fix, 2-FF synchroniser, tick-qualified stability counter,
// level with press/release pulses and, with PB_DEBOUNCE_LONGPRESS_EN, a long-press hold counter.
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int   DB_MS   = DEF_DB_MS,
  parameter int   LONG_MS = DEF_LONG_MS,
  parameter logic INV     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_raw,
  output chan_state_e o_state,
  output logic        o_rise,
  output logic        o_fall,
  output logic        o_long
);

  localparam int             CW       = bits_for(DB_MS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_MS - 1);

  if (DB_MS < 1 || LONG_MS < 1) begin : g_bad_param
    $error("pb_debounce_chan: DB_MS and LONG_MS must be at least 1");
  end

  logic          w_in_p;
  logic          w_mismatch;
  logic          r_sync1;
  logic          r_s;
  logic [CW-1:0] r_cnt;
  chan_state_e   r_state;
  logic          r_rise;
  logic          r_fall;

  assign w_in_p     = i_raw ^ INV;
  assign w_mismatch = (r_s != (r_state == ACTIVE));

  // The level only moves on a tick that completes DB_MS consecutive ticks of mismatch;
  // any cycle where the synchronised input agrees with the level restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= w_in_p;
      r_s     <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_state <= r_s ? ACTIVE : IDLE;
          r_rise  <= r_s;
          r_fall  <= ~r_s;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_state = r_state;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

`ifdef PB_DEBOUNCE_LONGPRESS_EN
  localparam int             HW       = bits_for(LONG_MS + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_MS);

  logic [HW-1:0] r_hold;
  logic          r_long;

  // Saturating hold counter; the pulse fires only on the increment that lands on HOLD_MAX.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == IDLE) begin
        r_hold <= '0;
      end else if (i_tick && (r_hold != HOLD_MAX)) begin
        r_hold <= r_hold + HW'(1);
        r_long <= (r_hold == (HOLD_MAX - HW'(1)));
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_array.sv
// NCH-channel pushbutton/switch debouncer sharing one millisecond prescaler.
// Define PB_DEBOUNCE_LONGPRESS_EN to build per-channel long-press pulse generation.
module pb_debounce_array
  import pb_debounce_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter int             PRESCALE = DEF_PRESCALE,
  parameter int             DB_MS    = DEF_DB_MS,
  parameter logic [NCH-1:0] INV_MASK = {NCH{1'b1}},
  parameter int             LONG_MS  = DEF_LONG_MS
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] db_in,
  output logic [NCH-1:0] db_out,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] long_press,
  output logic           tick
);

  localparam int            PW     = bits_for(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  if (NCH < 1 || NCH > 32 || PRESCALE < 1) begin : g_bad_param
    $error("pb_debounce_array: NCH must be 1..32 and PRESCALE at least 1");
  end

  logic [PW-1:0] r_pcnt;
  logic          w_tick;
  chan_state_e   w_state [NCH];

  // With PRESCALE=1 the counter is pinned at 0 == P_LAST, so the tick is continuous.
  assign w_tick = (r_pcnt == P_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pb_debounce_chan #(
      .DB_MS   (DB_MS),
      .LONG_MS (LONG_MS),
      .INV     (INV_MASK[g])
    ) u_chan (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_tick  (w_tick),
      .i_raw   (db_in[g]),
      .o_state (w_state[g]),
      .o_rise  (rise[g]),
      .o_fall  (fall[g]),
      .o_long  (long_press[g])
    );

    assign db_out[g] = (w_state[g] == ACTIVE);
  end

endmodule
